// File: rtl/ysyx_22040750_trap_ctrl_pkg.sv
// Shared constants for the trap sequencer: CSR addresses, mcause codes,
// mtvec mode encodings and the sequencer state encoding.
package ysyx_22040750_trap_ctrl_pkg;

  localparam logic [11:0] CsrMstatus  = 12'h300;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMscratch = 12'h340;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;

  localparam logic [63:0] McauseEcallM = 64'hb;
  localparam logic [63:0] McauseMtimer = 64'h8000_0000_0000_0007;

  localparam logic [1:0] MtvecDirect   = 2'b00;
  localparam logic [1:0] MtvecVectored = 2'b01;

  typedef enum logic {
    StIdle     = 1'b0,
    StRedirect = 1'b1
  } trap_state_e;

endpackage

// File: rtl/ysyx_22040750_trap_ctrl_trap_target.sv
// Trap target PC from the CSR read value: aligned base, plus 4*cause for
// vectored interrupts. Reserved mtvec modes fall back to direct.
module ysyx_22040750_trap_target
  import ysyx_22040750_trap_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic            is_irq,
  input  logic [PC_W-1:0] mtvec,
  input  logic [PC_W-3:0] cause_code,
  output logic [PC_W-1:0] target
);

  logic [PC_W-1:0] base;
  logic [PC_W-1:0] vec_off;

  always_comb begin
    base    = {mtvec[PC_W-1:2], 2'b00};
    vec_off = {cause_code, 2'b00};
    if (is_irq && (mtvec[1:0] == MtvecVectored)) begin
      target = base + vec_off;
    end else begin
      target = base;
    end
  end

endmodule

// File: rtl/ysyx_22040750_trap_ctrl.sv
// Trap sequencer at MEM/WB: decodes ecall/mret/timer irq, drives the CSR
// strobes, latches the redirect target and holds flush until fetch accepts.
module ysyx_22040750_trap_ctrl
  import ysyx_22040750_trap_ctrl_pkg::*;
#(
  parameter int unsigned      PC_W          = 32,
  parameter int unsigned      XLEN          = 64,
  parameter logic [XLEN-1:0]  CAUSE_ECALL_M = McauseEcallM,
  parameter logic [XLEN-1:0]  CAUSE_MTIMER  = McauseMtimer
) (
  input  logic            I_sys_clk,
  input  logic            I_rst,
  input  logic            I_wb_valid,
  input  logic            I_wb_ecall,
  input  logic            I_wb_mret,
  input  logic [PC_W-1:0] I_wb_pc,
  input  logic [PC_W-1:0] I_wb_next_pc,
  input  logic            I_timer_irq,
  input  logic            I_csr_mie,
  input  logic            I_csr_mtie,
  input  logic [XLEN-1:0] I_csr_rd_data,
  output logic            O_csr_intr_wr,
  output logic            O_csr_intr_rd,
  output logic            O_csr_mret_wr,
  output logic            O_csr_mret_rd,
  output logic [PC_W-1:0] O_intr_pc,
  output logic [XLEN-1:0] O_intr_no,
  output logic            O_flush,
  output logic            O_redirect_valid,
  output logic [PC_W-1:0] O_redirect_pc,
  input  logic            I_redirect_ready
);

  trap_state_e     state_q, state_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            decode_en;
  logic            take_ecall, take_mret, take_irq, take_any;
  logic [PC_W-1:0] target;
  logic            unused_rd_hi;

  assign unused_rd_hi = ^I_csr_rd_data[XLEN-1:PC_W];

  // Events are only seen at a commit boundary while not already redirecting.
  assign decode_en  = (state_q == StIdle) && I_wb_valid;
  assign take_ecall = decode_en && I_wb_ecall;
  assign take_mret  = decode_en && I_wb_mret && !I_wb_ecall;
  assign take_irq   = decode_en && I_timer_irq && I_csr_mie && I_csr_mtie &&
                      !I_wb_ecall && !I_wb_mret;
  assign take_any   = take_ecall || take_mret || take_irq;

  // The interrupted instruction has completed, so mepc is its successor.
  assign O_intr_no     = take_irq ? CAUSE_MTIMER : CAUSE_ECALL_M;
  assign O_intr_pc     = take_irq ? I_wb_next_pc : I_wb_pc;
  assign O_redirect_pc = redirect_pc_q;

  ysyx_22040750_trap_target #(
    .PC_W (PC_W)
  ) u_trap_target (
    .is_irq     (take_irq),
    .mtvec      (I_csr_rd_data[PC_W-1:0]),
    .cause_code (CAUSE_MTIMER[PC_W-3:0]),
    .target     (target)
  );

  always_comb begin
    state_d          = state_q;
    redirect_pc_d    = redirect_pc_q;
    O_csr_intr_wr    = 1'b0;
    O_csr_intr_rd    = 1'b0;
    O_csr_mret_wr    = 1'b0;
    O_csr_mret_rd    = 1'b0;
    O_flush          = 1'b0;
    O_redirect_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (take_ecall || take_irq) begin
          O_csr_intr_wr = 1'b1;
          O_csr_intr_rd = 1'b1;
        end
        if (take_mret) begin
          O_csr_mret_wr = 1'b1;
          O_csr_mret_rd = 1'b1;
        end
        if (take_any) begin
          O_flush       = 1'b1;
          state_d       = StRedirect;
          redirect_pc_d = target;
        end
      end
      StRedirect: begin
        O_flush          = 1'b1;
        O_redirect_valid = 1'b1;
        if (I_redirect_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state_q       <= StIdle;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_trap_ctrl.sv
// Directed bench for the trap sequencer: a per-cycle behavioural model checks
// every output, and literal expectations pin the model on key vectors.
module tb_ysyx_22040750_trap_ctrl;

  localparam logic [63:0] CauseEcall = 64'hb;
  localparam logic [63:0] CauseTimer = 64'h8000_0000_0000_0007;

  logic        I_sys_clk = 1'b0;
  logic        I_rst;
  logic        I_wb_valid, I_wb_ecall, I_wb_mret;
  logic [31:0] I_wb_pc, I_wb_next_pc;
  logic        I_timer_irq, I_csr_mie, I_csr_mtie;
  logic [63:0] I_csr_rd_data;
  logic        O_csr_intr_wr, O_csr_intr_rd, O_csr_mret_wr, O_csr_mret_rd;
  logic [31:0] O_intr_pc;
  logic [63:0] O_intr_no;
  logic        O_flush, O_redirect_valid;
  logic [31:0] O_redirect_pc;
  logic        I_redirect_ready;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: is a redirect outstanding, and to where.
  bit          m_busy   = 1'b0;
  logic [31:0] m_target = '0;

  always #5 I_sys_clk = ~I_sys_clk;

  ysyx_22040750_trap_ctrl dut (
    .I_sys_clk        (I_sys_clk),
    .I_rst            (I_rst),
    .I_wb_valid       (I_wb_valid),
    .I_wb_ecall       (I_wb_ecall),
    .I_wb_mret        (I_wb_mret),
    .I_wb_pc          (I_wb_pc),
    .I_wb_next_pc     (I_wb_next_pc),
    .I_timer_irq      (I_timer_irq),
    .I_csr_mie        (I_csr_mie),
    .I_csr_mtie       (I_csr_mtie),
    .I_csr_rd_data    (I_csr_rd_data),
    .O_csr_intr_wr    (O_csr_intr_wr),
    .O_csr_intr_rd    (O_csr_intr_rd),
    .O_csr_mret_wr    (O_csr_mret_wr),
    .O_csr_mret_rd    (O_csr_mret_rd),
    .O_intr_pc        (O_intr_pc),
    .O_intr_no        (O_intr_no),
    .O_flush          (O_flush),
    .O_redirect_valid (O_redirect_valid),
    .O_redirect_pc    (O_redirect_pc),
    .I_redirect_ready (I_redirect_ready)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_target(input bit is_irq, input logic [63:0] rd);
    logic [31:0] t;
    t = rd[31:0] & 32'hFFFF_FFFC;
    if (is_irq && (rd[1:0] == 2'b01)) begin
      t = t + 32'(4 * (CauseTimer & 64'h7FFF_FFFF_FFFF_FFFF));
    end
    return t;
  endfunction

  always @(posedge I_sys_clk) begin
    if (I_rst) begin
      m_busy   <= 1'b0;
      m_target <= '0;
    end else if (m_busy) begin
      if (I_redirect_ready) m_busy <= 1'b0;
    end else if (I_wb_valid && (I_wb_ecall || I_wb_mret ||
                                (I_timer_irq && I_csr_mie && I_csr_mtie))) begin
      m_busy   <= 1'b1;
      m_target <= model_target(!I_wb_ecall && !I_wb_mret, I_csr_rd_data);
    end
  end

  always @(negedge I_sys_clk) begin
    bit e_ecall, e_mret, e_irq;
    if (chk_en) begin
      e_ecall = !m_busy && I_wb_valid && I_wb_ecall;
      e_mret  = !m_busy && I_wb_valid && I_wb_mret && !I_wb_ecall;
      e_irq   = !m_busy && I_wb_valid && !I_wb_ecall && !I_wb_mret &&
                I_timer_irq && I_csr_mie && I_csr_mtie;
      check("m_intr_wr", 64'(O_csr_intr_wr), 64'(e_ecall || e_irq));
      check("m_intr_rd", 64'(O_csr_intr_rd), 64'(e_ecall || e_irq));
      check("m_mret_wr", 64'(O_csr_mret_wr), 64'(e_mret));
      check("m_mret_rd", 64'(O_csr_mret_rd), 64'(e_mret));
      check("m_flush", 64'(O_flush), 64'(m_busy || e_ecall || e_mret || e_irq));
      check("m_valid", 64'(O_redirect_valid), 64'(m_busy));
      if (m_busy) check("m_redirect_pc", 64'(O_redirect_pc), 64'(m_target));
      if (e_ecall || e_irq) begin
        check("m_intr_no", O_intr_no, e_irq ? CauseTimer : CauseEcall);
        check("m_intr_pc", 64'(O_intr_pc), 64'(e_irq ? I_wb_next_pc : I_wb_pc));
      end
    end
  end

  task automatic cyc();
    @(posedge I_sys_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge I_sys_clk);
  endtask

  task automatic idle_in();
    I_wb_valid       = 1'b0;
    I_wb_ecall       = 1'b0;
    I_wb_mret        = 1'b0;
    I_redirect_ready = 1'b0;
  endtask

  initial begin
    I_rst = 1'b1;
    idle_in();
    I_timer_irq = 1'b0; I_csr_mie = 1'b0; I_csr_mtie = 1'b0;
    I_csr_rd_data = '0; I_wb_pc = '0; I_wb_next_pc = '0;
    cyc(); cyc();
    chk_en = 1'b1;
    at_neg();
    check("rst_valid", 64'(O_redirect_valid), 64'd0);
    check("rst_flush", 64'(O_flush), 64'd0);
    check("rst_redirect_pc", 64'(O_redirect_pc), 64'd0);
    check("rst_intr_wr", 64'(O_csr_intr_wr), 64'd0);
    check("rst_mret_wr", 64'(O_csr_mret_wr), 64'd0);
    cyc(); I_rst = 1'b0;

    // ecall, ready held low three cycles, with an ecall arriving mid-redirect
    I_wb_valid = 1'b1; I_wb_ecall = 1'b1; I_wb_pc = 32'h8000_0010;
    I_wb_next_pc = 32'h8000_0014; I_csr_rd_data = 64'h8000_0100;
    at_neg();
    check("ecall_intr_wr", 64'(O_csr_intr_wr), 64'd1);
    check("ecall_intr_rd", 64'(O_csr_intr_rd), 64'd1);
    check("ecall_intr_no", O_intr_no, 64'hb);
    check("ecall_intr_pc", 64'(O_intr_pc), 64'h8000_0010);
    check("ecall_flush", 64'(O_flush), 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); idle_in();
      if (i == 1) begin
        I_wb_valid = 1'b1; I_wb_ecall = 1'b1; I_csr_rd_data = 64'h9000_0000;
      end
      at_neg();
      check("ecall_hold_valid", 64'(O_redirect_valid), 64'd1);
      check("ecall_hold_pc", 64'(O_redirect_pc), 64'h8000_0100);
      check("ecall_hold_flush", 64'(O_flush), 64'd1);
      if (i == 1) check("busy_ecall_ignored", 64'(O_csr_intr_wr), 64'd0);
    end
    cyc(); idle_in(); I_redirect_ready = 1'b1;
    at_neg();
    check("ecall_ready_valid", 64'(O_redirect_valid), 64'd1);
    cyc(); idle_in();
    at_neg();
    check("ecall_done_valid", 64'(O_redirect_valid), 64'd0);
    check("ecall_done_flush", 64'(O_flush), 64'd0);

    // mret, accepted in its first redirect cycle
    cyc(); I_wb_valid = 1'b1; I_wb_mret = 1'b1; I_csr_rd_data = 64'h8000_0014;
    at_neg();
    check("mret_wr", 64'(O_csr_mret_wr), 64'd1);
    check("mret_no_intr_wr", 64'(O_csr_intr_wr), 64'd0);
    cyc(); idle_in(); I_redirect_ready = 1'b1;
    at_neg();
    check("mret_redirect_pc", 64'(O_redirect_pc), 64'h8000_0014);

    // vectored timer interrupt
    cyc(); idle_in();
    I_wb_valid = 1'b1; I_timer_irq = 1'b1; I_csr_mie = 1'b1; I_csr_mtie = 1'b1;
    I_wb_pc = 32'h8000_001c; I_wb_next_pc = 32'h8000_0020; I_csr_rd_data = 64'h8000_0101;
    at_neg();
    check("irq_intr_no", O_intr_no, 64'h8000_0000_0000_0007);
    check("irq_intr_pc", 64'(O_intr_pc), 64'h8000_0020);
    cyc(); idle_in(); I_redirect_ready = 1'b1;
    at_neg();
    check("irq_vec_pc", 64'(O_redirect_pc), 64'h8000_011c);
    cyc(); idle_in(); I_timer_irq = 1'b0;

    // ecall beats a pending irq; irq then taken on the very next commit
    I_wb_valid = 1'b1; I_wb_ecall = 1'b1; I_timer_irq = 1'b1;
    I_wb_pc = 32'h8000_0030; I_csr_rd_data = 64'h8000_0200;
    at_neg();
    check("prio_intr_no", O_intr_no, 64'hb);
    cyc(); idle_in(); I_redirect_ready = 1'b1;
    at_neg();
    check("prio_redirect_pc", 64'(O_redirect_pc), 64'h8000_0200);
    cyc(); idle_in(); I_wb_valid = 1'b1; I_wb_next_pc = 32'h8000_0208;
    at_neg();
    check("b2b_irq_intr_no", O_intr_no, 64'h8000_0000_0000_0007);
    check("b2b_irq_intr_pc", 64'(O_intr_pc), 64'h8000_0208);
    cyc(); idle_in(); I_redirect_ready = 1'b1;
    at_neg();
    check("b2b_irq_pc", 64'(O_redirect_pc), 64'h8000_0200);

    // no commit, then masked by MIE, then masked by MTIE
    cyc(); idle_in();
    at_neg();
    check("novalid_flush", 64'(O_flush), 64'd0);
    cyc(); I_wb_valid = 1'b1; I_csr_mie = 1'b0;
    at_neg();
    check("mie0_intr_wr", 64'(O_csr_intr_wr), 64'd0);
    cyc(); I_csr_mie = 1'b1; I_csr_mtie = 1'b0;
    at_neg();
    check("mtie0_flush", 64'(O_flush), 64'd0);

    // reserved mtvec mode 11 behaves as direct; vectored target wraps
    cyc(); I_csr_mtie = 1'b1; I_csr_rd_data = 64'h8000_0103;
    at_neg();
    check("mode3_intr_wr", 64'(O_csr_intr_wr), 64'd1);
    cyc(); idle_in(); I_redirect_ready = 1'b1;
    at_neg();
    check("mode3_pc", 64'(O_redirect_pc), 64'h8000_0100);
    cyc(); idle_in(); I_wb_valid = 1'b1; I_csr_rd_data = 64'hFFFF_FFF1;
    cyc(); idle_in(); I_redirect_ready = 1'b1;
    at_neg();
    check("wrap_pc", 64'(O_redirect_pc), 64'h0000_000c);
    cyc(); idle_in(); I_timer_irq = 1'b0;

    // reset while redirecting
    I_wb_valid = 1'b1; I_wb_ecall = 1'b1; I_csr_rd_data = 64'h8000_0100;
    cyc(); idle_in(); I_rst = 1'b1;
    at_neg();
    check("rstmid_before_valid", 64'(O_redirect_valid), 64'd1);
    cyc(); I_rst = 1'b0;
    at_neg();
    check("rstmid_valid", 64'(O_redirect_valid), 64'd0);
    check("rstmid_flush", 64'(O_flush), 64'd0);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040750_trap_ctrl.md
Name: ysyx_22040750_trap_ctrl

Overview:
Trap sequencer directly upstream of the CSR file. It watches the instruction committing at MEM/WB and detects ecall, mret and the machine timer interrupt. It drives the CSR trap/mret write and read strobes, with mcause and mepc values, and captures the CSR read value (mtvec or mepc) as the redirect target. It then holds a flush plus a valid/ready redirect to the fetch stage until the redirect is accepted.

Parameters:
- PC_W, 32, PC width; matches the CSR intr_pc port.
- XLEN, 64, CSR data width.
- CAUSE_ECALL_M, 64'hb, mcause value for ecall from M-mode.
- CAUSE_MTIMER, 64'h8000000000000007, mcause value for machine timer interrupt.

Ports:
- I_sys_clk  in  1  clock
- I_rst  in  1  synchronous, active-high reset
- I_wb_valid  in  1  an instruction commits this cycle
- I_wb_ecall  in  1  committing instruction is ecall
- I_wb_mret  in  1  committing instruction is mret
- I_wb_pc  in  PC_W  PC of committing instruction
- I_wb_next_pc  in  PC_W  architectural next PC of committing instruction
- I_timer_irq  in  1  level MTIP from CLINT
- I_csr_mie  in  1  mstatus.MIE (bit 3)
- I_csr_mtie  in  1  mie.MTIE enable
- I_csr_rd_data  in  XLEN  CSR read port (mtvec or mepc, selected by the strobes below)
- O_csr_intr_wr  out  1  write mepc/mcause and stack MIE
- O_csr_intr_rd  out  1  select mtvec on the CSR read port
- O_csr_mret_wr  out  1  restore MIE from MPIE
- O_csr_mret_rd  out  1  select mepc on the CSR read port
- O_intr_pc  out  PC_W  value for mepc
- O_intr_no  out  XLEN  value for mcause
- O_flush  out  1  squash all younger in-flight instructions
- O_redirect_valid  out  1  redirect PC is valid
- O_redirect_pc  out  PC_W  new fetch PC
- I_redirect_ready  in  1  fetch accepts the redirect

Behaviour:
- FSM states: IDLE and REDIRECT, in a 1-bit register.
- Reset: state=IDLE, redirect_pc register=0. All outputs are 0, except that O_intr_pc and O_intr_no are combinational and may be nonzero.
- Event decode (Mealy, IDLE only, requires I_wb_valid=1). Priority: ecall > mret > interrupt.
  - take_ecall = I_wb_ecall.
  - take_mret = I_wb_mret & ~I_wb_ecall.
  - take_irq = I_timer_irq & I_csr_mie & I_csr_mtie & ~I_wb_ecall & ~I_wb_mret.
- ecall: O_csr_intr_wr=O_csr_intr_rd=1, O_intr_no=CAUSE_ECALL_M, O_intr_pc=I_wb_pc.
- irq: O_csr_intr_wr=O_csr_intr_rd=1, O_intr_no=CAUSE_MTIMER, O_intr_pc=I_wb_next_pc. The committing instruction completes before the trap is taken.
- mret: O_csr_mret_wr=O_csr_mret_rd=1.
- At most one strobe pair is active in any cycle. All strobes are 0 outside the IDLE decode cycle.
- Target computation, on the same edge as the event:
  - ecall or mret: redirect_pc <= I_csr_rd_data[PC_W-1:0] with bits [1:0] cleared.
  - irq with mtvec[1:0]==2'b01 (vectored): redirect_pc <= {base[PC_W-1:2],2'b00} + 4*7, taking the low bits of the cause.
  - irq with mtvec[1:0] of 00, 10 or 11: treat as direct mode.
  - Addition wraps modulo 2^PC_W.
- Transition on any event: IDLE -> REDIRECT.
- O_flush=1 in the event cycle (combinational) and throughout REDIRECT.
- O_redirect_valid=1 only in REDIRECT. O_redirect_pc is stable while valid.
- REDIRECT -> IDLE on I_redirect_ready=1. Ready may be asserted in the first REDIRECT cycle, giving a minimum occupancy of 1 cycle.
- Back-to-back: the cycle after the return to IDLE may decode a new event.
- In REDIRECT, I_wb_valid, ecall, mret and irq are ignored, because younger instructions are being flushed. A pending level irq is re-evaluated in IDLE.
- Interrupt masked (MIE=0 or MTIE=0): no action; the irq remains pending.
- Reset mid-REDIRECT: the next state is IDLE and valid/flush drop in the cycle after the reset edge.
- No trap is taken when I_wb_valid=0, even if irq is pending. Interrupts are accepted only at commit boundaries.

Decomposition:
- Shared package: CSR address constants (MEPC, MSTATUS, MTVEC, MCAUSE, MSCRATCH), mcause codes, mtvec mode encodings, FSM state encoding.
- Sub-module ysyx_22040750_trap_target: combinational mtvec-mode and cause to target PC computation.

Test Plan:
- ecall at I_wb_pc=32'h80000010, mtvec=32'h80000100 -> intr_wr/rd pulse 1 cycle, intr_no=64'hb, intr_pc=32'h80000010; next cycle redirect_valid=1, redirect_pc=32'h80000100, flush=1; ready held low 3 cycles -> stays 3 cycles, drops after ready.
- mret, mepc=32'h80000014 -> mret_wr/rd pulse, redirect_pc=32'h80000014, no intr_wr.
- Timer irq with MIE=1, MTIE=1, mtvec=32'h80000101 (vectored), next_pc=32'h80000020 -> intr_no=64'h8000000000000007, intr_pc=32'h80000020, redirect_pc=32'h8000011c.
- Simultaneous ecall+irq -> ecall taken (cause 64'hb). After redirect accepted, next commit with irq still high -> irq trap taken.
- irq with MIE=0, or with I_wb_valid=0 -> no strobes, no flush. Ecall arriving during REDIRECT -> ignored.
- I_rst asserted in REDIRECT -> following cycle valid=0, flush=0, state IDLE.
